// File: rtl/fu_result_writeback.sv
// fu_result_writeback: buffers FunctionalUnit results in a small FIFO and streams them to memory via req/ack.
// Build option WB_PARITY_EN: an even-parity bit is stored per entry and driven as the MSB of mem_wdata.
module fu_result_writeback #(
   parameter int NBITS       = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NBITS-1:0]         fu_data,
   input  logic                     fu_data_rdy,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic                     start,
   output logic                     mem_wr_en,
   output logic [ADDR_W-1:0]        mem_addr,
`ifdef WB_PARITY_EN
   output logic [NBITS:0]           mem_wdata,
`else
   output logic [NBITS-1:0]         mem_wdata,
`endif
   input  logic                     mem_ack,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     wr_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = $clog2(ACK_TIMEOUT) + 1;
`ifdef WB_PARITY_EN
   localparam int WD = NBITS + 1;
`else
   localparam int WD = NBITS;
`endif
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_REQ  = 3'b010,
      S_GAP  = 3'b100
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WD-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_addr_cnt;
   logic [TO_W-1:0]   r_to_cnt;
   logic              r_overflow;
   logic              r_wr_err;

   logic              w_rdy;
   logic              w_push;
   logic              w_pop;
   logic              w_timeout;
   logic              w_start_ok;
   logic              w_full;
   logic              w_empty;
   logic [WD-1:0]     w_entry;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);

`ifdef WB_PARITY_EN
   assign w_entry = {^fu_data, fu_data};
`else
   assign w_entry = fu_data;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_rdy = 1'b0;
      if (fu_data_rdy) w_rdy = 1'b1;  // an idle FU may float rdy; only a clean 1 is a result
      w_push     = w_rdy && (!w_full || w_pop);
      w_start_ok = start && (r_state == S_IDLE) && w_empty;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_pop     = 1'b0;
      w_timeout = 1'b0;
      unique case (r_state)
         S_IDLE: if (!w_empty) w_next = S_REQ;
         S_REQ: begin
            if (mem_ack) begin
               w_pop  = 1'b1;
               w_next = S_GAP;
            end else if (r_to_cnt == TO_LAST) begin
               w_timeout = 1'b1;
               w_next    = S_GAP;
            end
         end
         S_GAP:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_entry;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Timeout counter restarts whenever the FSM is outside REQ, so each REQ entry starts from zero.
   always_ff @(posedge clk) begin
      if (reset)                   r_to_cnt <= '0;
      else if (r_state != S_REQ)   r_to_cnt <= '0;
      else if (!mem_ack)           r_to_cnt <= r_to_cnt + 1'b1;
   end

   // A honoured start implies IDLE and empty, so it never coincides with pop, drop or timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_cnt <= '0;
         r_overflow <= 1'b0;
         r_wr_err   <= 1'b0;
      end else if (w_start_ok) begin
         r_addr_cnt <= base_addr;
         r_overflow <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         if (w_pop)            r_addr_cnt <= r_addr_cnt + 1'b1;
         if (w_rdy && !w_push) r_overflow <= 1'b1;
         if (w_timeout)        r_wr_err   <= 1'b1;
      end
   end

   assign mem_wr_en = (r_state == S_REQ);
   assign mem_addr  = r_addr_cnt;
   assign mem_wdata = mem_wr_en ? r_mem[r_rd_ptr] : '0;
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_fu_result_writeback.sv
// Randomised scoreboard bench for fu_result_writeback; reference model works on a queue of pending results.
module tb_fu_result_writeback;

   localparam int NBITS       = 8;
   localparam int ADDR_W      = 8;
   localparam int DEPTH       = 4;
   localparam int ACK_TIMEOUT = 16;
`ifdef WB_PARITY_EN
   localparam int WD = NBITS + 1;
`else
   localparam int WD = NBITS;
`endif
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clk;
   logic              reset;
   logic [NBITS-1:0]  fu_data;
   logic              fu_data_rdy;
   logic [ADDR_W-1:0] base_addr;
   logic              start;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [WD-1:0]     mem_wdata;
   logic              mem_ack;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              wr_err;

   fu_result_writeback #(
      .NBITS(NBITS), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .fu_data(fu_data), .fu_data_rdy(fu_data_rdy),
      .base_addr(base_addr), .start(start), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .full(full), .empty(empty),
      .count(count), .overflow(overflow), .wr_err(wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WD-1:0] exp_wdata(input logic [NBITS-1:0] d);
`ifdef WB_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   // Reference model: results accepted but not yet written, in order, plus the next write address.
   logic [NBITS-1:0]  sb_q[$];
   logic [ADDR_W-1:0] exp_addr;
   bit                exp_ovf, exp_werr, exp_drop, after_reset, model_valid;
   int                run_len;
   int                n_writes;
   bit                m_pop, m_push;

   initial begin
      model_valid = 0; after_reset = 0; exp_drop = 0; run_len = 0; n_writes = 0;
      exp_addr = '0; exp_ovf = 0; exp_werr = 0;
   end

   // Monitor: compare state produced by the previous edge, then advance the model across the next edge.
   always @(negedge clk) begin
      if (model_valid) begin
         check("count", count, sb_q.size());
         check("empty", empty, (sb_q.size() == 0));
         check("full", full, (sb_q.size() == DEPTH));
         check("overflow", overflow, exp_ovf);
         check("wr_err", wr_err, exp_werr);
         if (after_reset) begin
            check("reset_wr_en", mem_wr_en, 0);
            check("reset_addr", mem_addr, 0);
            check("reset_wdata", mem_wdata, 0);
         end
         if (exp_drop) check("req_drop_on_timeout", mem_wr_en, 0);
         if (mem_wr_en) begin
            if (sb_q.size() == 0) check("req_without_data", mem_wr_en, 0);
            else begin
               check("mem_addr", mem_addr, exp_addr);
               check("mem_wdata", mem_wdata, exp_wdata(sb_q[0]));
            end
         end
      end
      after_reset = 0;
      exp_drop    = 0;
      if (reset) begin
         sb_q.delete();
         exp_addr = '0; exp_ovf = 0; exp_werr = 0; run_len = 0;
         model_valid = 1; after_reset = 1;
      end else if (model_valid) begin
         m_pop  = mem_wr_en && mem_ack && (sb_q.size() > 0);
         m_push = 0;
         if (start) begin
            exp_addr = base_addr; exp_ovf = 0; exp_werr = 0;
         end
         if (fu_data_rdy === 1'b1) begin
            if (sb_q.size() < DEPTH || m_pop) m_push = 1;
            else exp_ovf = 1;
         end
         if (mem_wr_en && !mem_ack) begin
            run_len++;
            if (run_len == ACK_TIMEOUT) begin
               exp_werr = 1; exp_drop = 1; run_len = 0;
            end
         end else run_len = 0;
         if (m_pop) begin
            void'(sb_q.pop_front());
            exp_addr = exp_addr + 1'b1;
            n_writes++;
         end
         if (m_push) sb_q.push_back(fu_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit rdy, input logic [NBITS-1:0] d, input bit ack, input bit st = 0);
      fu_data_rdy = rdy;
      fu_data     = d;
      mem_ack     = ack;
      start       = st;
      tick();
   endtask

   task automatic wait_drain(input int budget);
      int quiet = 0;
      for (int i = 0; i < budget && quiet < 3; i++) begin
         drive(0, NBITS'($urandom()), 1);
         if (sb_q.size() == 0 && !mem_wr_en) quiet++;
         else quiet = 0;
      end
      check("drain_within_budget", (quiet >= 3), 1);
   endtask

   task automatic wait_req(input int budget);
      for (int i = 0; i < budget && !mem_wr_en; i++) drive(0, NBITS'($urandom()), 0);
      check("req_seen", mem_wr_en, 1);
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input bit rdy = 0,
                           input logic [NBITS-1:0] d = '0);
      wait_drain(200);
      base_addr = b;
      drive(rdy, d, 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      reset = 1; fu_data_rdy = 0; fu_data = '0; mem_ack = 0; start = 0; base_addr = '0;

      // Reset and idle
      repeat (3) drive(0, NBITS'($urandom()), 0);
      reset = 0;
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_empty", empty, 1);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      repeat (3) drive(0, NBITS'($urandom()), 1);
      check("idle_no_push", empty, 1);

      // Single write, ack two cycles after request
      do_start(8'h10);
      wr0 = n_writes;
      drive(1, 8'hAA, 0);
      wait_req(10);
      check("single_addr", mem_addr, 8'h10);
      drive(0, '0, 0);
      drive(0, '0, 1);
      wait_drain(50);
      check("single_write_count", n_writes - wr0, 1);
      check("single_empty", empty, 1);

      // Back-to-back pulses fill the FIFO, then drain in order
      do_start(8'h10);
      for (int i = 1; i <= 4; i++) drive(1, NBITS'(i), 0);
      check("b2b_full", full, 1);
      wait_drain(100);

      // Overflow: six results with no ack keep only the first four
      do_start(8'h20);
      for (int i = 0; i < 6; i++) drive(1, NBITS'(8'hC0 + i), 0);
      check("ovf_count", count, DEPTH);
      check("ovf_flag", overflow, 1);
      wait_drain(100);
      do_start(8'h30);
      drive(0, '0, 0);
      check("ovf_cleared_by_start", overflow, 0);

      // Ack timeout with retry, and address wrap
      do_start(8'hFF);
      drive(1, 8'h5A, 0);
      for (int i = 0; i < ACK_TIMEOUT + 4; i++) drive(0, '0, 0);
      check("timeout_wr_err", wr_err, 1);
      wait_req(10);
      check("retry_addr", mem_addr, 8'hFF);
      wait_drain(50);
      drive(1, 8'h66, 0);
      wait_req(10);
      check("wrap_addr", mem_addr, 8'h00);
      wait_drain(50);
      do_start(8'h00);
      drive(0, '0, 0);
      check("wr_err_cleared_by_start", wr_err, 0);

      // start coincident with a push: address loads first
      do_start(8'h40, 1, 8'h3C);
      wait_req(10);
      check("start_push_addr", mem_addr, 8'h40);
      wait_drain(50);

      // Parity-relevant values
      drive(1, 8'h07, 0);
      drive(1, 8'h03, 0);
      wait_drain(50);

      // Reset in the middle of a request
      drive(1, 8'h99, 0);
      wait_req(10);
      reset = 1;
      drive(0, '0, 0);
      reset = 0;
      check("mid_req_reset_wr_en", mem_wr_en, 0);
      check("mid_req_reset_empty", empty, 1);
      drive(0, '0, 1);

      // Randomised traffic
      for (int blk = 0; blk < 5; blk++) begin
         do_start(ADDR_W'($urandom()));
         for (int i = 0; i < 300; i++)
            drive(bit'($urandom_range(0, 1)), NBITS'($urandom()), ($urandom_range(0, 9) < 4));
      end
      wait_drain(200);
      check("final_queue_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
